// File: rtl/mem_responder.sv
// mem_responder: cache-side backing-store responder.
//
// Holds a 2^ADDR_W x DATA_W storage array. After reset the whole array is
// zeroed, one word per cycle (INIT). It then accepts one request at a time:
// a refill read or a dirty-word writeback. Each request is served after
// LATENCY access cycles and completes with a one-cycle response pulse.
//
// Parameters
//   ADDR_W   word address width (storage depth 2^ADDR_W)
//   DATA_W   data word width
//   LATENCY  access cycles per request, 1..15
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   req        request strobe, sampled only while busy=0
//   req_write  1 = writeback, 0 = refill read
//   req_addr   word address of the request
//   req_data   writeback data (ignored for reads)
//   busy       high while initialising or servicing a request
//   rdata      refill data, held until the next read completes
//   rvalid     one-cycle pulse: refill data on rdata
//   wdone      one-cycle pulse: writeback committed to storage
module mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              busy,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              wdone
);

  localparam int         DEPTH  = 1 << ADDR_W;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   init_cnt;
  logic [3:0]          lat_cnt;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                write_p0;
  logic [ADDR_W-1:0]   addr_p0;
  logic [DATA_W-1:0]   data_p0;

  logic                accept;
  logic                last_access;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  assign accept      = (state == IDLE) && req;
  assign last_access = (state == ACCESS) && (lat_cnt == 4'd0);

  // Stage 0: request capture on the accept edge; later input changes are
  // invisible to the operation in flight.
  always_ff @(posedge clk) begin
    if (accept) begin
      write_p0 <= req_write;
      addr_p0  <= req_addr;
      data_p0  <= req_data;
    end
  end

  // Storage write port: the INIT sweep and committed writebacks. Gated by
  // rst_n so that clock edges while reset is held leave storage untouched.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr_p0;
    mem_wdata = data_p0;
    if (rst_n) begin
      if (state == INIT) begin
        mem_we    = 1'b1;
        mem_waddr = init_cnt;
        mem_wdata = '0;
      end else if (last_access && write_p0) begin
        mem_we = 1'b1;
      end
    end
  end

  // Storage has no reset: only the INIT sweep clears it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Stage 1: control FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      init_cnt <= '0;
      lat_cnt  <= 4'd0;
      busy     <= 1'b1;
      rvalid   <= 1'b0;
      wdone    <= 1'b0;
      rdata    <= '0;
    end else begin
      rvalid <= 1'b0;
      wdone  <= 1'b0;
      case (state)
        INIT: begin
          init_cnt <= init_cnt + ADDR_W'(1);
          if (init_cnt == {ADDR_W{1'b1}}) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (req) begin
            state   <= ACCESS;
            busy    <= 1'b1;
            lat_cnt <= LAT_M1;
          end
        end
        ACCESS: begin
          // lat_cnt reaching zero marks the final access edge; with
          // LATENCY=1 it is loaded with zero and never decremented.
          if (lat_cnt == 4'd0) begin
            state <= RESP;
            if (write_p0) begin
              wdone <= 1'b1;
            end else begin
              rvalid <= 1'b1;
              rdata  <= mem[addr_p0];
            end
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= INIT;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: one instance at LATENCY=3, one at LATENCY=1.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        req0, req_write0;
  logic [7:0]  req_addr0;
  logic [15:0] req_data0;
  logic        busy0, rvalid0, wdone0;
  logic [15:0] rdata0;

  logic        req1, req_write1;
  logic [7:0]  req_addr1;
  logic [15:0] req_data1;
  logic        busy1, rvalid1, wdone1;
  logic [15:0] rdata1;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(8), .DATA_W(16), .LATENCY(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req(req0), .req_write(req_write0), .req_addr(req_addr0), .req_data(req_data0),
    .busy(busy0), .rdata(rdata0), .rvalid(rvalid0), .wdone(wdone0)
  );

  mem_responder #(.ADDR_W(8), .DATA_W(16), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req(req1), .req_write(req_write1), .req_addr(req_addr1), .req_data(req_data1),
    .busy(busy1), .rdata(rdata1), .rvalid(rvalid1), .wdone(wdone1)
  );

  typedef struct {
    logic        w;
    logic [7:0]  a;
    logic [15:0] d;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic accept0(input logic w, input logic [7:0] a, input logic [15:0] d);
    int g = 0;
    while (busy0 && g < 600) begin
      tick;
      g++;
    end
    if (busy0) check("accept_wait_timeout", busy0, 0);
    req0 = 1'b1; req_write0 = w; req_addr0 = a; req_data0 = d;
    tick;
    req0 = 1'b0;
  endtask

  task automatic wait_pulse0(output int edges);
    edges = 0;
    do begin
      tick;
      edges++;
    end while (!(rvalid0 || wdone0) && edges < 20);
  endtask

  task automatic run_op0(input string name, input logic w, input logic [7:0] a,
                         input logic [15:0] d, input logic [15:0] exp_rd);
    int e;
    accept0(w, a, d);
    wait_pulse0(e);
    check({name, "_latency"}, e, 3);
    check({name, "_rvalid"}, rvalid0, !w);
    check({name, "_wdone"}, wdone0, w);
    check({name, "_rdata"}, rdata0, exp_rd);
    tick;
    check({name, "_busy_after"}, busy0, 0);
    check({name, "_pulse_after"}, rvalid0 | wdone0, 0);
  endtask

  initial begin
    int cnt;
    int seen;
    int e;
    int pulses;
    int pend;
    int acc_edges[$];
    logic prev_busy;

    vecs[0] = '{1'b0, 8'hFF, 16'h0000, 16'h0000};
    vecs[1] = '{1'b1, 8'h5A, 16'h1234, 16'h0000};
    vecs[2] = '{1'b0, 8'h5A, 16'h0000, 16'h1234};
    vecs[3] = '{1'b1, 8'h00, 16'hFFFF, 16'h1234};
    vecs[4] = '{1'b1, 8'hFF, 16'h8001, 16'h1234};
    vecs[5] = '{1'b0, 8'h00, 16'h0000, 16'hFFFF};
    vecs[6] = '{1'b0, 8'hFF, 16'h0000, 16'h8001};
    vecs[7] = '{1'b0, 8'h5B, 16'h0000, 16'h0000};
    vecs[8] = '{1'b1, 8'h5A, 16'h0F0F, 16'h0000};
    vecs[9] = '{1'b0, 8'h5A, 16'h0000, 16'h0F0F};

    req0 = 0; req_write0 = 0; req_addr0 = 0; req_data0 = 0;
    req1 = 0; req_write1 = 0; req_addr1 = 0; req_data1 = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", busy0, 1);
    check("rst_rvalid", rvalid0, 0);
    check("rst_wdone", wdone0, 0);
    check("rst_rdata", rdata0, 0);
    check("rst_busy_lat1", busy1, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    cnt = 0;
    while (busy0 && cnt < 1000) begin
      tick;
      cnt++;
    end
    check("init_busy_cycles", cnt, 256);
    check("init_done_lat1", busy1, 0);
    check("init_no_pulse", rvalid0 | wdone0, 0);

    for (int i = 0; i < 10; i++)
      run_op0($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp);

    // Held request: back-to-back reads of 0x01.. spaced LATENCY+2 edges.
    for (int k = 1; k <= 4; k++)
      run_op0($sformatf("prefill%0d", k), 1'b1, 8'(k), 16'(16'h1111 * k), 16'h0F0F);
    prev_busy = busy0;
    pulses = 0;
    pend = 1;
    req0 = 1'b1; req_write0 = 1'b0; req_addr0 = 8'h01;
    for (int i = 1; i <= 18; i++) begin
      tick;
      if (rvalid0 || wdone0) begin
        pulses++;
        check("held_rvalid", rvalid0, 1);
        check("held_rdata", rdata0, 32'h1111 * pend);
        pend++;
      end
      if (!prev_busy && busy0) begin
        acc_edges.push_back(i);
        req_addr0 = req_addr0 + 8'd1;
      end
      prev_busy = busy0;
    end
    req0 = 1'b0;
    check("held_accept_count", acc_edges.size(), 4);
    for (int k = 0; k < acc_edges.size(); k++)
      check($sformatf("held_accept_edge%0d", k), acc_edges[k], 1 + 5 * k);
    check("held_pulse_count", pulses, 3);
    wait_pulse0(e);
    check("held_last_latency", e, 1);
    check("held_last_rdata", rdata0, 16'h4444);
    tick;

    // Request inputs change right after the accept edge.
    accept0(1'b1, 8'h10, 16'hAAAA);
    req_data0 = 16'h5555; req_write0 = 1'b0; req_addr0 = 8'h11;
    wait_pulse0(e);
    check("wb_latency", e, 3);
    check("wb_wdone", wdone0, 1);
    check("wb_rvalid", rvalid0, 0);
    tick;
    run_op0("wb_read11", 1'b0, 8'h11, 16'h0, 16'h0000);
    run_op0("wb_read10", 1'b0, 8'h10, 16'h0, 16'hAAAA);

    // Reset in the middle of a write's ACCESS phase.
    accept0(1'b1, 8'h20, 16'hBEEF);
    tick;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy0, 1);
    check("midrst_rvalid", rvalid0, 0);
    check("midrst_wdone", wdone0, 0);
    check("midrst_rdata", rdata0, 0);
    seen = 0;
    repeat (3) begin
      tick;
      if (wdone0 || rvalid0) seen++;
    end
    req0 = 1'b1; req_write0 = 1'b1; req_addr0 = 8'h30; req_data0 = 16'h7777;
    rst_n = 1'b1;
    cnt = 0;
    while (busy0 && cnt < 1000) begin
      tick;
      cnt++;
      if (wdone0 || rvalid0) seen++;
    end
    req0 = 1'b0;
    check("reinit_busy_cycles", cnt, 256);
    check("reinit_no_pulse", seen, 0);
    run_op0("reinit_read20", 1'b0, 8'h20, 16'h0, 16'h0000);
    run_op0("reinit_read30", 1'b0, 8'h30, 16'h0, 16'h0000);
    run_op0("reinit_read5a", 1'b0, 8'h5A, 16'h0, 16'h0000);

    // LATENCY=1 instance.
    req1 = 1'b1; req_write1 = 1'b1; req_addr1 = 8'h07; req_data1 = 16'hC3C3;
    tick;
    req1 = 1'b0;
    tick;
    check("l1_wdone", wdone1, 1);
    check("l1_w_rvalid", rvalid1, 0);
    tick;
    check("l1_w_busy_after", busy1, 0);
    req1 = 1'b1; req_write1 = 1'b0; req_addr1 = 8'h07;
    tick;
    req1 = 1'b0;
    tick;
    check("l1_rvalid", rvalid1, 1);
    check("l1_rdata", rdata1, 16'hC3C3);
    check("l1_r_wdone", wdone1, 0);
    req1 = 1'b1; req_write1 = 1'b1; req_addr1 = 8'h07; req_data1 = 16'hDEAD;
    tick;
    req1 = 1'b0;
    check("l1_resp_req_ignored_busy", busy1, 0);
    seen = 0;
    repeat (3) begin
      tick;
      if (wdone1 || rvalid1 || busy1) seen++;
    end
    check("l1_resp_req_no_activity", seen, 0);
    req1 = 1'b1; req_write1 = 1'b0; req_addr1 = 8'h07;
    tick;
    req1 = 1'b0;
    tick;
    check("l1_reread_rvalid", rvalid1, 1);
    check("l1_reread_rdata", rdata1, 16'hC3C3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
